// File: rtl/polyphase_merge_if.sv
// polyphase_merge_if: even/odd input lanes and merged output handshake bundle
interface polyphase_merge_if #(
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 4
);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   logic                  even_valid;
   logic                  even_ready;
   logic [DATA_WIDTH-1:0] even_data;
   logic                  odd_valid;
   logic                  odd_ready;
   logic [DATA_WIDTH-1:0] odd_data;
   logic                  y_valid;
   logic                  y_ready;
   logic [DATA_WIDTH-1:0] y_data;
   logic                  y_phase;
   logic [LW-1:0]         even_level;
   logic [LW-1:0]         odd_level;
   modport slave (
      input  even_valid, even_data, odd_valid, odd_data, y_ready,
      output even_ready, odd_ready, y_valid, y_data, y_phase, even_level, odd_level
   );
   modport master (
      output even_valid, even_data, odd_valid, odd_data, y_ready,
      input  even_ready, odd_ready, y_valid, y_data, y_phase, even_level, odd_level
   );
endinterface

// File: rtl/polyphase_merge.sv
// polyphase_merge: interleaves even/odd phase lanes into one full-rate stream
module polyphase_merge #(
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 4
) (
   input logic              clk,
   input logic              rst,
   input logic              restart,
   polyphase_merge_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   logic [DATA_WIDTH-1:0] mem [2][FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr [2];
   logic [AW-1:0]         rd_ptr [2];
   logic [LW-1:0]         level [2];
   logic [DATA_WIDTH-1:0] din [2];
   logic [1:0]            in_valid, in_ready, push, pop;
   logic                  nxt, load, y_valid, y_phase;
   logic [DATA_WIDTH-1:0] y_data;
   always_comb begin
      in_valid = {bus.odd_valid, bus.even_valid};
      din[0] = bus.even_data;
      din[1] = bus.odd_data;
      for (int i = 0; i < 2; i++) in_ready[i] = level[i] != LW'(FIFO_DEPTH) && !restart && !rst;
      push = in_valid & in_ready;
      load = (!y_valid || bus.y_ready) && level[nxt] != '0;
      pop = load ? (nxt ? 2'b10 : 2'b01) : 2'b00;
   end
   always_ff @(posedge clk)
      for (int i = 0; i < 2; i++) if (push[i]) mem[i][wr_ptr[i]] <= din[i];
   // the phase pointer only advances on a load, so a missing phase stalls the stream
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            level[i] <= '0;
         end
         nxt <= 1'b0;
         y_valid <= 1'b0;
         y_data <= '0;
         y_phase <= 1'b0;
      end else if (restart) begin
         for (int i = 0; i < 2; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            level[i] <= '0;
         end
         nxt <= 1'b0;
         y_valid <= 1'b0;
         y_data <= '0;
         y_phase <= 1'b0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            wr_ptr[i] <= wr_ptr[i] + AW'(push[i]);
            rd_ptr[i] <= rd_ptr[i] + AW'(pop[i]);
            level[i] <= level[i] + LW'(push[i]) - LW'(pop[i]);
         end
         if (load) begin
            y_data <= mem[nxt][rd_ptr[nxt]];
            y_phase <= nxt;
            nxt <= !nxt;
            y_valid <= 1'b1;
         end else if (bus.y_ready) y_valid <= 1'b0;
      end
   assign bus.even_ready = in_ready[0];
   assign bus.odd_ready = in_ready[1];
   assign bus.even_level = level[0];
   assign bus.odd_level = level[1];
   assign bus.y_valid = y_valid;
   assign bus.y_data = y_data;
   assign bus.y_phase = y_phase;
endmodule

// File: tb/tb_polyphase_merge.sv
// tb_polyphase_merge: directed vectors plus a queue model of the even/odd interleave
module tb_polyphase_merge;
   localparam int DW = 16;
   localparam int D = 4;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic restart = 1'b0;
   always #5 clk = ~clk;
   polyphase_merge_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(D)) bus ();
   polyphase_merge #(.DATA_WIDTH(DW), .FIFO_DEPTH(D)) dut (
      .clk(clk), .rst(rst), .restart(restart), .bus(bus.slave)
   );
   int total = 0;
   int bad = 0;
   logic [DW-1:0] eq [$];
   logic [DW-1:0] oq [$];
   int cnt = 0;
   logic hold = 1'b0;
   logic [DW-1:0] hold_data;
   logic hold_phase;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // lane contents = pushed and not yet handed downstream; output k comes from lane k%2
   always @(negedge clk) begin
      if (!rst) begin
         logic [31:0] e;
         chk("even_inflight", 32'(bus.even_level) + 32'(bus.y_valid && !bus.y_phase), eq.size());
         chk("odd_inflight", 32'(bus.odd_level) + 32'(bus.y_valid && bus.y_phase), oq.size());
         chk("even_ready", bus.even_ready, 32'(bus.even_level != D && !restart));
         chk("odd_ready", bus.odd_ready, 32'(bus.odd_level != D && !restart));
         if (bus.y_valid) begin
            e = 'x;
            if (cnt % 2 == 1 && oq.size() > 0) e = oq[0];
            if (cnt % 2 == 0 && eq.size() > 0) e = eq[0];
            chk("model_phase", bus.y_phase, cnt % 2);
            chk("model_data", bus.y_data, e);
         end
         if (hold) begin
            chk("hold_data", bus.y_data, hold_data);
            chk("hold_phase", bus.y_phase, hold_phase);
         end
         hold = bus.y_valid && !bus.y_ready && !restart;
         hold_data = bus.y_data;
         hold_phase = bus.y_phase;
         if (restart) begin
            eq.delete();
            oq.delete();
            cnt = 0;
         end else begin
            if (bus.even_valid && bus.even_ready) eq.push_back(bus.even_data);
            if (bus.odd_valid && bus.odd_ready) oq.push_back(bus.odd_data);
            if (bus.y_valid && bus.y_ready) begin
               if (cnt % 2 == 1) void'(oq.pop_front());
               else void'(eq.pop_front());
               cnt++;
            end
         end
      end else hold = 1'b0;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lanes(input logic ev, input logic [DW-1:0] ed, input logic ov, input logic [DW-1:0] od);
      bus.even_valid = ev;
      bus.even_data = ed;
      bus.odd_valid = ov;
      bus.odd_data = od;
   endtask

   task automatic chk_out(input string name, input logic [DW-1:0] d, input logic p);
      chk({name, "_valid"}, bus.y_valid, 1);
      chk({name, "_data"}, bus.y_data, d);
      chk({name, "_phase"}, bus.y_phase, p);
   endtask

   task automatic run_interleave(input string name);
      bus.y_ready = 1'b1;
      lanes(1, 16'd1, 1, 16'd2); tick();
      chk({name, "_nobypass"}, bus.y_valid, 0);
      lanes(1, 16'd3, 1, 16'd4); tick(); chk_out({name, "_o1"}, 16'd1, 0);
      lanes(1, 16'd5, 1, 16'd6); tick(); chk_out({name, "_o2"}, 16'd2, 1);
      lanes(0, 0, 0, 0);         tick(); chk_out({name, "_o3"}, 16'd3, 0);
      tick(); chk_out({name, "_o4"}, 16'd4, 1);
      tick(); chk_out({name, "_o5"}, 16'd5, 0);
      tick(); chk_out({name, "_o6"}, 16'd6, 1);
      tick(); chk({name, "_drained"}, bus.y_valid, 0);
   endtask

   initial begin
      lanes(0, 0, 0, 0);
      bus.y_ready = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk("rst_y_valid", bus.y_valid, 0);
      chk("rst_y_data", bus.y_data, 0);
      chk("rst_y_phase", bus.y_phase, 0);
      chk("rst_even_ready", bus.even_ready, 0);
      chk("rst_odd_ready", bus.odd_ready, 0);
      chk("rst_even_level", bus.even_level, 0);
      chk("rst_odd_level", bus.odd_level, 0);
      tick(); tick();
      rst = 1'b0;
      run_interleave("t2");

      lanes(1, 16'h00A0, 0, 0); tick();
      lanes(1, 16'h00B0, 0, 0); tick(); chk_out("t3_a0", 16'h00A0, 0);
      lanes(0, 0, 0, 0);        tick(); chk("t3_stall", bus.y_valid, 0);
      lanes(0, 0, 1, 16'h00C0); tick(); chk("t3_stall2", bus.y_valid, 0);
      lanes(0, 0, 0, 0);        tick(); chk_out("t3_c0", 16'h00C0, 1);
      tick(); chk_out("t3_b0", 16'h00B0, 0);
      tick(); chk("t3_drained", bus.y_valid, 0);

      restart = 1'b1; tick(); restart = 1'b0;
      bus.y_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         lanes(1, 16'(i * 16'h11), 0, 0);
         tick();
      end
      chk_out("t4_held", 16'h0011, 0);
      chk("t4_even_level", bus.even_level, 4);
      chk("t4_even_ready", bus.even_ready, 0);
      lanes(1, 16'h0066, 0, 0); tick(); tick();
      chk("t4_full_ready", bus.even_ready, 0);
      chk("t4_full_level", bus.even_level, 4);
      chk_out("t4_still", 16'h0011, 0);
      lanes(0, 0, 0, 0);

      restart = 1'b1; tick(); restart = 1'b0;
      lanes(1, 16'h0101, 1, 16'h0201); tick();
      lanes(1, 16'h0102, 1, 16'h0202); tick();
      lanes(1, 16'h0103, 0, 0);        tick();
      lanes(1, 16'h0104, 0, 0);        tick();
      chk("t5_even_level", bus.even_level, 3);
      chk("t5_odd_level", bus.odd_level, 2);
      chk_out("t5_held", 16'h0101, 0);
      lanes(1, 16'h0105, 1, 16'h0205);
      bus.y_ready = 1'b1;
      restart = 1'b1;
      #1;
      chk("t5_rs_even_ready", bus.even_ready, 0);
      chk("t5_rs_odd_ready", bus.odd_ready, 0);
      tick();
      restart = 1'b0;
      lanes(0, 0, 0, 0);
      chk("t5_even_level0", bus.even_level, 0);
      chk("t5_odd_level0", bus.odd_level, 0);
      chk("t5_y_valid0", bus.y_valid, 0);
      chk("t5_y_phase0", bus.y_phase, 0);
      lanes(0, 0, 1, 16'h0099); tick();
      lanes(0, 0, 0, 0);        tick(); chk("t5_wait_even", bus.y_valid, 0);
      lanes(1, 16'h0088, 0, 0); tick();
      lanes(0, 0, 0, 0);        tick(); chk_out("t5_88", 16'h0088, 0);
      tick(); chk_out("t5_99", 16'h0099, 1);
      tick(); chk("t5_drained", bus.y_valid, 0);

      lanes(1, 16'h0031, 1, 16'h0032); tick();
      lanes(1, 16'h0033, 1, 16'h0034); tick();
      chk("t6_pre_valid", bus.y_valid, 1);
      #2 rst = 1'b1;
      lanes(0, 0, 0, 0);
      eq.delete();
      oq.delete();
      cnt = 0;
      #1;
      chk("t6_y_valid", bus.y_valid, 0);
      chk("t6_y_data", bus.y_data, 0);
      chk("t6_y_phase", bus.y_phase, 0);
      chk("t6_even_level", bus.even_level, 0);
      chk("t6_odd_level", bus.odd_level, 0);
      chk("t6_even_ready", bus.even_ready, 0);
      chk("t6_odd_ready", bus.odd_ready, 0);
      tick();
      rst = 1'b0;
      run_interleave("t6");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
